posit_encoder: RTL and testbench
================================

# posit_encoder

Packs a decoded posit (sign, regime value, exponent, fraction, sticky) back into an N-bit posit word, with round-to-nearest-even and saturation. It is the output stage for the adder datapath: it consumes the regime/exponent/fraction fields that the extraction and alignment logic produce and returns a standard posit encoding. Encoding is iterative, one body bit per cycle, with valid/ready handshakes on both sides.

## Interface
- N, 8, posit word width
- ES, 3, exponent field width
- RS, log2(N), regime value width minus one (regime port is RS+1 bits, signed)
- FW, N, fraction width (bits below the hidden one)
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  input fields valid
- in_ready  output  1  encoder can accept (high only in IDLE)
- in_sign  input  1  sign of the result
- in_regime  input  RS+1  signed regime value k
- in_exp  input  ES  exponent e
- in_frac  input  FW  fraction, MSB-first, hidden bit excluded
- in_sticky  input  1  OR of fraction bits already discarded upstream
- in_zero  input  1  result is zero (overrides fields)
- in_nar  input  1  result is NaR (overrides in_zero and fields)
- out_valid  output  1  out_posit valid
- out_ready  input  1  consumer accepts out_posit
- out_posit  output  N  encoded posit

## Operation
- States: IDLE, SHIFT, ROUND, HOLD.
- IDLE: in_ready=1. On in_valid, capture all inputs.
  - in_nar, in_zero, or saturation -> HOLD with the special word.
  - Otherwise -> SHIFT with bit counter=0.
- Special words: NaR=1000..0; zero=0..0.
- Saturation: k>N-2 gives magnitude maxpos 0111..1. k<-(N-2) gives minpos 000..01. Negate if sign.
- Body stream, MSB-first:
  - Regime run: k+1 ones then a 0 if k>=0; -k zeros then a 1 if k<0.
  - Then in_exp (ES bits), then in_frac (FW bits), then zeros.
- SHIFT: emits one stream bit per cycle into the body register, for N-1 cycles (counter 0..N-2).
- ROUND, one cycle:
  - guard = stream bit N-1.
  - sticky = OR of all later stream bits | in_sticky.
  - Increment body if guard & (lsb | sticky).
  - An increment that would overflow past 0111..1 saturates to maxpos. The result is never 0 or NaR.
  - Prepend sign 0. If in_sign, take the two's complement of the N-bit word. Register into out_posit and go to HOLD.
- HOLD: out_valid=1, out_posit stable. When out_ready=1 -> IDLE on the same edge.
- New input is accepted only in IDLE, so there is no overlap. Worst-case throughput is one result per N+2 cycles.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, out_valid=0, out_posit=0, counter=0. in_ready reads 1 (IDLE decode). in_valid is ignored while rst_n is low.
- Normal path: accept edge T. SHIFT occupies cycles T+1..T+N-1, ROUND occupies T+N, out_valid rises after edge T+N+1. Latency is N+1 cycles.
- Special and saturated path: out_valid rises after edge T+1. Latency is 1 cycle.
- out_posit changes only on the ROUND->HOLD or IDLE->HOLD transition. It is held through any out_ready stall.
- in_valid high outside IDLE is ignored. Upstream must hold its fields until in_ready & in_valid.
- rst_n low mid-SHIFT, ROUND or HOLD: immediate return to reset values; the pending result is discarded.

## Structure
- posit_pkg holds:
  - the log2 function;
  - the state enum (IDLE, SHIFT, ROUND, HOLD);
  - NaR, zero, maxpos and minpos constant functions of N.
- One sub-module, posit_stream_bit: combinational. Given k, exp, frac and a bit index, it returns the stream bit. It also provides the tail-OR used for sticky. The encoder instantiates it for the shift index and the guard index.

## Test plan
- Basic: N=8, ES=3, k=0, e=0, frac=0x00 -> out_posit=0x40 after 9 cycles. in_ready=0 throughout SHIFT, ROUND and HOLD.
- Sign: k=-1, e=5, frac=0x80, sign=0 -> 0x36. Same with sign=1 -> 0xCA.
- Rounding: k=0, e=0:
  - frac=0x60 -> 0x42 (round up);
  - frac=0x20, sticky=0 -> 0x40 (tie to even);
  - frac=0x20, sticky=1 -> 0x41.
- Saturation and specials, all with 1-cycle latency:
  - k=7 -> 0x7F; k=7, sign=1 -> 0x81; k=-7 -> 0x01;
  - in_zero -> 0x00; in_nar with in_zero -> 0x80.
  - k=6, e=7, frac=0xFF takes the full 9-cycle path -> 0x7F.
- Backpressure: out_ready low for 5 cycles in HOLD -> out_posit and out_valid stable, in_ready=0. Release -> IDLE next edge and next input accepted.
- Reset: drop rst_n in SHIFT cycle 3 -> out_valid=0 and out_posit=0 immediately. After release, a new input of k=0 -> 0x40 with normal latency.

Source files
------------

// File: rtl/posit_pkg.sv
// Shared types and constants for the posit encoder: state encoding, log2 helper
// and the special posit words as functions of the word width.
package posit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    HOLD  = 2'd3
  } enc_state_t;

  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [63:0] posit_nar(input int n);
    return 64'd1 << (n - 1);
  endfunction

  function automatic logic [63:0] posit_zero(input int n);
    return 64'd0 & {32'd0, 32'(n)};
  endfunction

  function automatic logic [63:0] posit_maxpos(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] posit_minpos(input int n);
    return (n > 0) ? 64'd1 : 64'd0;
  endfunction

endpackage

// File: rtl/posit_encoder_if.sv
// Handshake bundle between the adder datapath, the posit encoder and its consumer.
interface posit_encoder_if
  import posit_pkg::*;
#(
  parameter int N  = 8,
  parameter int ES = 3,
  parameter int RS = log2(N),
  parameter int FW = N
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_sign;
  logic signed [RS:0]   in_regime;
  logic [ES-1:0]        in_exp;
  logic [FW-1:0]        in_frac;
  logic                 in_sticky;
  logic                 in_zero;
  logic                 in_nar;
  logic                 out_valid;
  logic                 out_ready;
  logic [N-1:0]         out_posit;

  modport slave (
    input  in_valid, in_sign, in_regime, in_exp, in_frac, in_sticky, in_zero, in_nar,
    input  out_ready,
    output in_ready, out_valid, out_posit
  );

  modport master (
    output in_valid, in_sign, in_regime, in_exp, in_frac, in_sticky, in_zero, in_nar,
    output out_ready,
    input  in_ready, out_valid, out_posit
  );
endinterface

// File: rtl/posit_stream_bit.sv
// Combinational view of the posit body stream (regime run, exponent, fraction, zeros):
// returns the bit at a given index and the OR of every bit after it.
module posit_stream_bit #(
  parameter int ES   = 3,
  parameter int RS   = 3,
  parameter int FW   = 8,
  parameter int LMAX = 19,
  parameter int IW   = 5
) (
  input  logic signed [RS:0] k,
  input  logic [ES-1:0]      exp_field,
  input  logic [FW-1:0]      frac,
  input  logic [IW-1:0]      idx,
  output logic               stream_bit,
  output logic               tail_or
);

  function automatic logic bit_at(input int i, input int kk,
                                  input logic [ES-1:0] e, input logic [FW-1:0] f);
    int   rlen;
    int   j;
    logic b;
    b    = 1'b0;
    rlen = (kk >= 0) ? kk + 2 : 1 - kk;
    j    = i - rlen;
    if (i < rlen) begin
      // positive k: k+1 ones then terminator 0; negative k: -k zeros then terminator 1
      if (kk >= 0) b = (i <= kk);
      else         b = (i == -kk);
    end else if (j < ES) begin
      for (int x = 0; x < ES; x++) begin
        if (x == ES - 1 - j) b = e[x];
      end
    end else begin
      for (int x = 0; x < FW; x++) begin
        if (x == FW - 1 - (j - ES)) b = f[x];
      end
    end
    return b;
  endfunction

  // Stream bit at idx and the OR of all stream bits beyond idx
  always_comb begin
    stream_bit = bit_at(int'(idx), int'(k), exp_field, frac);
    tail_or    = 1'b0;
    for (int i = 0; i < LMAX; i++) begin
      if (i > int'(idx)) tail_or = tail_or | bit_at(i, int'(k), exp_field, frac);
      else               tail_or = tail_or;
    end
  end

endmodule

// File: rtl/posit_encoder.sv
// Iterative posit packer: serialises the body one bit per cycle, then applies
// round-to-nearest-even with saturation and the sign's two's complement.
module posit_encoder
  import posit_pkg::*;
#(
  parameter int N  = 8,
  parameter int ES = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  posit_encoder_if.slave  bus
);
  localparam int RS   = log2(N);
  localparam int FW   = N;
  localparam int LMAX = N + ES + FW;
  localparam int IW   = log2(LMAX);

  localparam logic [63:0] NAR_L    = posit_nar(N);
  localparam logic [63:0] ZERO_L   = posit_zero(N);
  localparam logic [63:0] MAXPOS_L = posit_maxpos(N);
  localparam logic [63:0] MINPOS_L = posit_minpos(N);
  localparam logic [N-1:0] NAR_W    = NAR_L[N-1:0];
  localparam logic [N-1:0] ZERO_W   = ZERO_L[N-1:0];
  localparam logic [N-1:0] MAXPOS_W = MAXPOS_L[N-1:0];
  localparam logic [N-1:0] MINPOS_W = MINPOS_L[N-1:0];

  localparam logic signed [RS:0] K_MAX     = (RS+1)'(N - 2);
  localparam logic signed [RS:0] K_MIN     = (RS+1)'(2 - N);
  localparam logic [RS-1:0]      CNT_LAST  = RS'(N - 2);
  localparam logic [IW-1:0]      GUARD_IDX = IW'(N - 1);
  localparam logic [N-2:0]       BODY_ONES = {(N-1){1'b1}};

  function automatic logic [N-1:0] apply_sign(input logic [N-1:0] w, input logic s);
    return s ? (~w + N'(1)) : w;
  endfunction

  enc_state_t         state_r;
  logic [RS-1:0]      cnt_r;
  logic [N-2:0]       body_r;
  logic signed [RS:0] k_r;
  logic [ES-1:0]      exp_r;
  logic [FW-1:0]      frac_r;
  logic               sign_r;
  logic               sticky_r;
  logic [N-1:0]       out_posit_r;
  logic               out_valid_r;
  logic               in_ready_r;

  logic               shift_bit_s;
  logic               shift_tail_unused_s;
  logic               guard_bit_s;
  logic               guard_tail_s;
  logic               special_s;
  logic [N-1:0]       special_word_s;
  logic               round_inc_s;
  logic [N-2:0]       mag_s;
  logic [N-1:0]       final_word_s;

  posit_stream_bit #(.ES(ES), .RS(RS), .FW(FW), .LMAX(LMAX), .IW(IW)) u_shift_bit (
    .k(k_r), .exp_field(exp_r), .frac(frac_r), .idx(IW'(cnt_r)),
    .stream_bit(shift_bit_s), .tail_or(shift_tail_unused_s)
  );

  posit_stream_bit #(.ES(ES), .RS(RS), .FW(FW), .LMAX(LMAX), .IW(IW)) u_guard_bit (
    .k(k_r), .exp_field(exp_r), .frac(frac_r), .idx(GUARD_IDX),
    .stream_bit(guard_bit_s), .tail_or(guard_tail_s)
  );

  // Special-word decode on the live inputs; NaR dominates zero, zero dominates saturation
  always_comb begin
    special_s      = 1'b1;
    special_word_s = ZERO_W;
    if (bus.in_nar) begin
      special_word_s = NAR_W;
    end else if (bus.in_zero) begin
      special_word_s = ZERO_W;
    end else if (bus.in_regime > K_MAX) begin
      special_word_s = apply_sign(MAXPOS_W, bus.in_sign);
    end else if (bus.in_regime < K_MIN) begin
      special_word_s = apply_sign(MINPOS_W, bus.in_sign);
    end else begin
      special_s      = 1'b0;
      special_word_s = ZERO_W;
    end
  end

  // Round-to-nearest-even on the collected body; an all-ones body saturates at maxpos
  always_comb begin
    round_inc_s = guard_bit_s & (body_r[0] | guard_tail_s | sticky_r);
    if (round_inc_s && (body_r != BODY_ONES)) mag_s = body_r + (N-1)'(1);
    else                                      mag_s = body_r;
    final_word_s = apply_sign({1'b0, mag_s}, sign_r);
  end

  // Encoder FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      body_r      <= '0;
      k_r         <= '0;
      exp_r       <= '0;
      frac_r      <= '0;
      sign_r      <= 1'b0;
      sticky_r    <= 1'b0;
      out_posit_r <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            k_r        <= bus.in_regime;
            exp_r      <= bus.in_exp;
            frac_r     <= bus.in_frac;
            sign_r     <= bus.in_sign;
            sticky_r   <= bus.in_sticky;
            in_ready_r <= 1'b0;
            if (special_s) begin
              out_posit_r <= special_word_s;
              out_valid_r <= 1'b1;
              state_r     <= HOLD;
            end else begin
              cnt_r   <= '0;
              state_r <= SHIFT;
            end
          end
        end
        SHIFT: begin
          body_r <= {body_r[N-3:0], shift_bit_s};
          if (cnt_r == CNT_LAST) state_r <= ROUND;
          else                   cnt_r   <= cnt_r + RS'(1);
        end
        ROUND: begin
          out_posit_r <= final_word_s;
          out_valid_r <= 1'b1;
          state_r     <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_posit = out_posit_r;

endmodule

// File: tb/tb_posit_encoder.sv
// Directed-vector bench for posit_encoder (N=8, ES=3) with hand-computed results.
module tb_posit_encoder;
  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  posit_encoder_if #(.N(8), .ES(3), .RS(3), .FW(8)) bus ();

  posit_encoder #(.N(8), .ES(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic sgn, input int k, input logic [2:0] e, input logic [7:0] f,
                       input logic st, input logic z, input logic na);
    bus.in_sign   = sgn;
    bus.in_regime = 4'(k);
    bus.in_exp    = e;
    bus.in_frac   = f;
    bus.in_sticky = st;
    bus.in_zero   = z;
    bus.in_nar    = na;
  endtask

  // Present one vector, count cycles from the accept edge until out_valid, check word
  task automatic run_vec(input string tag, input logic sgn, input int k, input logic [2:0] e,
                         input logic [7:0] f, input logic st, input logic z, input logic na,
                         input logic [7:0] exp_word, input int exp_lat);
    int lat;
    int busy_ready;
    @(negedge clk);
    check({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
    drive(sgn, k, e, f, st, z, na);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    lat        = 0;
    busy_ready = 0;
    while (lat < 30) begin
      @(negedge clk);
      lat++;
      bus.in_valid = 1'b0;
      if (bus.in_ready) busy_ready++;
      if (bus.out_valid) break;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_word"}, 32'(bus.out_posit), 32'(exp_word));
    check({tag, "_busy"}, 32'(busy_ready), 32'd0);
  endtask

  initial begin
    int lat;
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_posit", 32'(bus.out_posit), 32'd0);
    rst_n = 1'b1;

    run_vec("basic",    1'b0,  0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h40, 9);
    run_vec("sign_pos", 1'b0, -1, 3'd5, 8'h80, 1'b0, 1'b0, 1'b0, 8'h36, 9);
    run_vec("sign_neg", 1'b1, -1, 3'd5, 8'h80, 1'b0, 1'b0, 1'b0, 8'hCA, 9);
    run_vec("rnd_up",   1'b0,  0, 3'd0, 8'h60, 1'b0, 1'b0, 1'b0, 8'h42, 9);
    run_vec("rnd_tie",  1'b0,  0, 3'd0, 8'h20, 1'b0, 1'b0, 1'b0, 8'h40, 9);
    run_vec("rnd_stk",  1'b0,  0, 3'd0, 8'h20, 1'b1, 1'b0, 1'b0, 8'h41, 9);
    run_vec("sat_hi",   1'b0,  7, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h7F, 1);
    run_vec("sat_hi_n", 1'b1,  7, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h81, 1);
    run_vec("sat_lo",   1'b0, -7, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 1);
    run_vec("zero",     1'b0,  0, 3'd3, 8'h55, 1'b0, 1'b1, 1'b0, 8'h00, 1);
    run_vec("nar",      1'b0,  0, 3'd3, 8'h55, 1'b0, 1'b1, 1'b1, 8'h80, 1);
    run_vec("k6_full",  1'b0,  6, 3'd7, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h7F, 9);

    // Backpressure: stall HOLD for 5 cycles while a new request waits upstream
    @(negedge clk);
    drive(1'b0, 0, 3'd0, 8'h60, 1'b0, 1'b0, 1'b0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    drive(1'b0, -7, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    lat = 1;
    while (lat < 30 && !bus.out_valid) begin
      @(negedge clk);
      lat++;
    end
    check("bp_lat", 32'(lat), 32'd9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_word", 32'(bus.out_posit), 32'h42);
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_rel_ready", 32'(bus.in_ready), 32'd1);
    check("bp_rel_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_next_valid", 32'(bus.out_valid), 32'd1);
    check("bp_next_word", 32'(bus.out_posit), 32'h01);

    // Reset in the third SHIFT cycle discards the pending result
    run_vec("pre_rst",  1'b1, -1, 3'd5, 8'h80, 1'b0, 1'b0, 1'b0, 8'hCA, 9);
    @(negedge clk);
    drive(1'b0, 0, 3'd0, 8'h60, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    check("mid_busy", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_posit", 32'(bus.out_posit), 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("post_rst", 1'b0,  0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h40, 9);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
